// File: rtl/gen_add_pkg.sv
// Shared constants and the result-width helper for the gen_add ripple adder.
package gen_add_pkg;

  localparam int GEN_ADD_DEFAULT_N = 4;

  // The sum plus the carry out of the top bit.
  function automatic int gen_add_result_width(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/gen_add_full_adder.sv
// One-bit full adder cell, chained by gen_add into a ripple-carry adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_p;

  assign w_p  = a ^ b;
  assign s    = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);

endmodule

// File: rtl/gen_add.sv
// N-bit ripple-carry adder with registered sum/carry (1-cycle latency).
// Define GEN_ADD_OVERFLOW_EN to add the registered signed-overflow output.
module gen_add
  import gen_add_pkg::*;
#(
  parameter int N = GEN_ADD_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  output logic [N-1:0] sum,
  output logic         carry_out
`ifdef GEN_ADD_OVERFLOW_EN
  ,
  output logic         overflow
`endif
);

  localparam int RW = gen_add_result_width(N);

  logic [N:0]    w_c;
  logic [N-1:0]  w_s;
  logic [RW-1:0] w_result;
  logic [RW-1:0] r_result;

  assign w_c[0] = carry_in;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_fa
      full_adder u_fa (
        .a    (a[gi]),
        .b    (b[gi]),
        .cin  (w_c[gi]),
        .s    (w_s[gi]),
        .cout (w_c[gi+1])
      );
    end
  endgenerate

  assign w_result = {w_c[N], w_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
    end else begin
      r_result <= w_result;
    end
  end

  assign sum       = r_result[N-1:0];
  assign carry_out = r_result[N];

`ifdef GEN_ADD_OVERFLOW_EN
  logic r_overflow;

  // Signed overflow: carries into and out of the sign bit disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_c[N] ^ w_c[N-1];
    end
  end

  assign overflow = r_overflow;
`endif

endmodule

// File: tb/tb_gen_add.sv
// Self-checking bench for gen_add at N=4, N=8 and N=1 against an arithmetic model.
// Overflow checks are compiled in when GEN_ADD_OVERFLOW_EN is defined.
module tb_gen_add;

  logic clk = 1'b0;
  logic rst;

  logic [3:0] a4, b4, sum4;
  logic       ci4, co4;
  logic [7:0] a8, b8, sum8;
  logic       ci8, co8;
  logic [0:0] a1, b1, sum1;
  logic       ci1, co1;
`ifdef GEN_ADD_OVERFLOW_EN
  logic       ov4, ov8, ov1;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  gen_add #(.N(4)) u_dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .carry_in(ci4),
    .sum(sum4), .carry_out(co4)
`ifdef GEN_ADD_OVERFLOW_EN
    , .overflow(ov4)
`endif
  );

  gen_add #(.N(8)) u_dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .carry_in(ci8),
    .sum(sum8), .carry_out(co8)
`ifdef GEN_ADD_OVERFLOW_EN
    , .overflow(ov8)
`endif
  );

  gen_add #(.N(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .carry_in(ci1),
    .sum(sum1), .carry_out(co1)
`ifdef GEN_ADD_OVERFLOW_EN
    , .overflow(ov1)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and step off it before sampling.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model: plain integer sum, and signed overflow from the true signed result range.
  task automatic expect_add(input string tag, input int n, input int ai, input int bi, input int ci);
    int total, sa, sb, ssum;
    logic [63:0] got_sum, got_co;
    logic exp_ovf;
    total = ai + bi + ci;
    sa = (ai >= (1 << (n - 1))) ? ai - (1 << n) : ai;
    sb = (bi >= (1 << (n - 1))) ? bi - (1 << n) : bi;
    ssum = sa + sb + ci;
    exp_ovf = (ssum > (1 << (n - 1)) - 1) || (ssum < -(1 << (n - 1)));
    got_sum = '0;
    got_co  = '0;
    case (n)
      4:       begin got_sum = 64'(sum4); got_co = 64'(co4); end
      8:       begin got_sum = 64'(sum8); got_co = 64'(co8); end
      default: begin got_sum = 64'(sum1); got_co = 64'(co1); end
    endcase
    $display("txn %s N=%0d a=%0h b=%0h ci=%0d -> sum=%0h co=%0d", tag, n, ai, bi, ci, got_sum, got_co);
    check({tag, "/sum"}, got_sum, 64'(total % (1 << n)));
    check({tag, "/co"}, got_co, 64'(total >> n));
`ifdef GEN_ADD_OVERFLOW_EN
    case (n)
      4:       check({tag, "/ovf"}, 64'(ov4), 64'(exp_ovf));
      8:       check({tag, "/ovf"}, 64'(ov8), 64'(exp_ovf));
      default: check({tag, "/ovf"}, 64'(ov1), 64'(exp_ovf));
    endcase
`else
    if (exp_ovf) begin end
`endif
  endtask

  task automatic expect_zero(input string tag);
    $display("txn %s reset -> sum4=%0h co4=%0d sum8=%0h co8=%0d", tag, sum4, co4, sum8, co8);
    check({tag, "/n4"}, {59'd0, co4, sum4}, 64'd0);
    check({tag, "/n8"}, {55'd0, co8, sum8}, 64'd0);
    check({tag, "/n1"}, {62'd0, co1, sum1}, 64'd0);
`ifdef GEN_ADD_OVERFLOW_EN
    check({tag, "/ovf"}, {61'd0, ov4, ov8, ov1}, 64'd0);
`endif
  endtask

  int seq_a [5] = '{1, 2, 4, 9, 13};
  int seq_b [5] = '{1, 2, 3, 4, 5};

  initial begin
    // Reset with all-ones operands: reset must win over capture.
    rst = 1'b1;
    a4 = 4'hF; b4 = 4'hF; ci4 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
    cyc();
    expect_zero("reset");

    // First edge out of reset reflects the inputs sampled there (all-ones boundary).
    rst = 1'b0;
    cyc();
    expect_add("ones4", 4, 15, 15, 1);
    expect_add("ones8", 8, 255, 255, 1);

    a4 = 4'h0; b4 = 4'h0; ci4 = 1'b0;
    cyc();
    expect_add("zero4", 4, 0, 0, 0);

    // Back-to-back directed sequence.
    for (int i = 0; i < 5; i++) begin
      a4 = 4'(seq_a[i]); b4 = 4'(seq_b[i]); ci4 = 1'b0;
      cyc();
      expect_add($sformatf("seq%0d", i), 4, seq_a[i], seq_b[i], 0);
    end

    a4 = 4'hF; b4 = 4'h0; ci4 = 1'b1;
    cyc();
    expect_add("f_0_c1", 4, 15, 0, 1);

    a4 = 4'h7; b4 = 4'h1; ci4 = 1'b0;
    cyc();
    expect_add("ovf_pos", 4, 7, 1, 0);

    a4 = 4'h8; b4 = 4'h8; ci4 = 1'b0;
    cyc();
    expect_add("ovf_neg", 4, 8, 8, 0);

    // Reset mid-stream discards the pending result, then resumes cleanly.
    a4 = 4'hD; b4 = 4'h5; ci4 = 1'b0;
    rst = 1'b1;
    cyc();
    expect_zero("mid_rst");
    rst = 1'b0;
    cyc();
    expect_add("post_rst", 4, 13, 5, 0);

    // N=1 exhaustive.
    for (int i = 0; i < 8; i++) begin
      a1 = 1'(i >> 2); b1 = 1'(i >> 1); ci1 = 1'(i);
      cyc();
      expect_add($sformatf("n1_%0d", i), 1, (i >> 2) & 1, (i >> 1) & 1, i & 1);
    end

    // N=8 random back-to-back, with one reset pulse partway through.
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      rst = (i == 500);
      cyc();
      if (i == 500) begin
        expect_zero("rnd_rst");
      end else begin
        expect_add($sformatf("rnd%0d", i), 8, int'(a8), int'(b8), int'(ci8));
      end
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gen_add.md
GEN_ADD -- requirements
Module: gen_add

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the operand and sum width in bits; legal range 1 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port a, input, N bits, addend A, unsigned.
REQ-005 The block SHALL have port b, input, N bits, addend B, unsigned.
REQ-006 The block SHALL have port carry_in, input, 1 bit, carry into bit 0.
REQ-007 The block SHALL have port sum, output, N bits, the registered low N bits of a+b+carry_in.
REQ-008 The block SHALL have port carry_out, output, 1 bit, the registered carry out of bit N-1.
REQ-009 The block SHALL have port overflow, output, 1 bit, registered two's-complement signed overflow; present only when GEN_ADD_OVERFLOW_EN is defined.

Function
REQ-010 The adder SHALL form {carry_out, sum} = a + b + carry_in as an (N+1)-bit result, with no truncation of the carry.
REQ-011 The adder SHALL be a ripple chain of N one-bit full adders: c[0]=carry_in, s[i]=a[i]^b[i]^c[i], c[i+1]=a[i]&b[i] | c[i]&(a[i]^b[i]), carry_out=c[N].
REQ-012 sum and carry_out SHALL be registered, with latency exactly 1 cycle: inputs sampled at edge k appear on the outputs after edge k and hold until edge k+1.
REQ-013 The adder SHALL accept new operands every cycle, with no handshake and no stall.
REQ-014 Boundary: all-ones + all-ones + 1 SHALL give sum all-ones and carry_out 1; all-zero inputs SHALL give 0 and 0.
REQ-015 overflow, when present, SHALL equal c[N] ^ c[N-1], registered with the same latency as sum.

Reset
REQ-016 When rst is 1 at a rising clk edge, sum, carry_out and overflow SHALL become 0 on that edge, regardless of a, b and carry_in.
REQ-017 rst SHALL take priority over the operand capture in the same cycle.
REQ-018 On the first edge with rst=0, the outputs SHALL reflect the inputs sampled at that edge.
REQ-019 Asserting reset mid-stream SHALL discard the pending result, with no carry-over of state.

Configuration
REQ-020 With macro GEN_ADD_OVERFLOW_EN defined, port overflow and its register SHALL exist and follow REQ-015.
REQ-021 With GEN_ADD_OVERFLOW_EN undefined, port overflow SHALL be absent, and sum and carry_out SHALL behave identically to the defined case.

Structure
REQ-022 Package gen_add_pkg SHALL hold constant GEN_ADD_DEFAULT_N = 4 and the helper type or function for the (N+1)-bit result width.
REQ-023 Sub-module full_adder (inputs a, b, cin; outputs s, cout) SHALL be instantiated N times via a generate loop.
REQ-024 gen_add SHALL hold only the generate chain and the output registers, with no other sub-modules.

Verification
REQ-025 N=4, carry_in=0, rst deasserted, sequence A/B = 0001/0001, 0010/0010, 0100/0011, 1001/0100, 1101/0101 -> one cycle later each, sum/carry = 0010/0, 0100/0, 0111/0, 1101/0, 0010/1.
REQ-026 N=4, A=1111, B=0000, carry_in=1 -> sum=0000, carry_out=1 after 1 cycle; with GEN_ADD_OVERFLOW_EN, overflow=0.
REQ-027 N=4, GEN_ADD_OVERFLOW_EN defined, A=0111, B=0001, carry_in=0 -> sum=1000, carry_out=0, overflow=1; A=1000, B=1000 -> sum=0000, carry_out=1, overflow=1.
REQ-028 rst=1 while A=1101, B=0101 -> sum=0000, carry_out=0 on that edge; release rst -> sum=0010, carry_out=1 on the next edge.
REQ-029 N=8, randomized back-to-back a, b, carry_in for 1000 cycles -> every output equals the golden (a+b+carry_in) of the previous cycle.
REQ-030 N=1, all 8 input combinations -> {carry_out, sum} equals a+b+carry_in, 1 cycle later.
